// File: rtl/glb_arb_pkg.sv
// glb_arb_pkg: shared state enum and width helpers for the GLB stream arbiter
package glb_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, FINISHED} arb_state_t;
  function automatic int id_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int b);
    return $clog2(b + 1);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational first-set picker scanning upward from start with wrap; ports req/start in, idx/hit out
module rr_pick
  import glb_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = id_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         hit
);
  logic [W-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(start) + k) % N);
      if (req[j]) idx = j;
    end
  end
  assign hit = |req;
endmodule

// File: rtl/glb_stream_arbiter.sv
// glb_stream_arbiter: round-robin burst-locked mux of NUM_SRC ready/valid streams onto one GLB port; src_* in, out_* to GLB, grant_id/all_done status
module glb_stream_arbiter
  import glb_arb_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 17,
  parameter int BURST_MAX = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]  src_data,
  input  logic [NUM_SRC-1:0]              src_valid,
  output logic [NUM_SRC-1:0]              src_ready,
  input  logic [NUM_SRC-1:0]              src_done,
  output logic [DATA_W-1:0]               out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [id_w(NUM_SRC)-1:0]        grant_id,
  output logic                            all_done
);
  localparam int IW = id_w(NUM_SRC);
  localparam int CW = cnt_w(BURST_MAX);
  arb_state_t state, state_n;
  logic [IW-1:0] rr_ptr, rr_n, gid_n, pick;
  logic [CW-1:0] beat_cnt, cnt_n;
  logic [NUM_SRC-1:0] done_seen;
  logic hit, granted, accepted, rel;
  rr_pick #(.N(NUM_SRC), .W(IW)) u_pick (
    .req  (src_valid & ~done_seen),
    .start(rr_ptr),
    .idx  (pick),
    .hit  (hit)
  );
  assign granted   = state == GRANT;
  assign out_data  = granted ? src_data[grant_id] : '0;
  assign out_valid = granted & src_valid[grant_id];
  assign src_ready = granted ? NUM_SRC'(out_ready) << grant_id : '0;
  assign all_done  = state == FINISHED;
  assign accepted  = out_valid & out_ready;
  // a done on the final beat still lets that beat through; release happens at the same edge
  assign rel = granted && ((accepted && beat_cnt == CW'(BURST_MAX - 1)) || src_done[grant_id]);
  always_comb begin
    state_n = state;
    rr_n = rr_ptr;
    gid_n = grant_id;
    cnt_n = beat_cnt;
    if (state == IDLE) begin
      if (&done_seen) state_n = FINISHED;
      else if (hit) begin
        state_n = GRANT;
        gid_n = pick;
        cnt_n = '0;
      end
    end else if (granted) begin
      if (accepted) cnt_n = beat_cnt + 1'b1;
      if (rel) begin
        state_n = IDLE;
        rr_n = grant_id == IW'(NUM_SRC - 1) ? '0 : grant_id + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      done_seen <= '0;
    end else if (flush) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      done_seen <= '0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_n;
      grant_id <= gid_n;
      beat_cnt <= cnt_n;
      done_seen <= done_seen | src_done;
    end
  end
endmodule
